// File: rtl/johnson_decode_checker_pkg.sv
// johnson_decode_checker_pkg: shared widths, limits and lock FSM encoding
package johnson_decode_checker_pkg;
  localparam int N_DEF = 8;
  localparam int IDX_W_DEF = $clog2(2 * N_DEF);
  localparam logic [7:0] ERR_MAX = 8'd255;
  typedef enum logic {ST_UNLOCKED = 1'b0, ST_LOCKED = 1'b1} state_t;
endpackage

// File: rtl/johnson_decode_checker_if.sv
// johnson_decode_checker_if: Johnson sample bus plus decoded/monitor results
interface johnson_decode_checker_if
  import johnson_decode_checker_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int IDX_W = IDX_W_DEF
) ();
  logic en;
  logic [N-1:0] jc;
  logic [IDX_W-1:0] idx;
  logic idx_vld;
  logic illegal;
  logic seq_err;
  logic locked;
  logic [7:0] err_cnt;
  modport master (output en, jc, input idx, idx_vld, illegal, seq_err, locked, err_cnt);
  modport slave (input en, jc, output idx, idx_vld, illegal, seq_err, locked, err_cnt);
endinterface

// File: rtl/johnson_to_bin.sv
// johnson_to_bin: combinational Johnson code word to binary index with legality flag
module johnson_to_bin #(
  parameter int N = 8,
  parameter int IDX_W = 4
) (
  input  logic [N-1:0]     jc,
  output logic             legal,
  output logic [IDX_W-1:0] idx_raw
);
  localparam logic [N-1:0] ONES = '1;
  // Leading-ones codes map to 0..N, leading-zeros codes to N+1..2N-1
  always_comb begin
    legal = 1'b0;
    idx_raw = '0;
    for (int i = 0; i <= N; i++)
      if (jc == ~(ONES >> i)) begin
        legal = 1'b1;
        idx_raw = IDX_W'(i);
      end
    for (int i = 1; i < N; i++)
      if (jc == (ONES >> i)) begin
        legal = 1'b1;
        idx_raw = IDX_W'(N + i);
      end
  end
endmodule

// File: rtl/johnson_decode_checker.sv
// johnson_decode_checker: decodes sampled Johnson words and monitors sequence lock/integrity
module johnson_decode_checker
  import johnson_decode_checker_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int IDX_W = IDX_W_DEF,
  parameter int LOCK_CNT = 3
) (
  input logic clk,
  input logic clr,
  johnson_decode_checker_if.slave bus
);
  state_t st, st_nx;
  logic [3:0] run, run_nx;
  logic [IDX_W-1:0] prev, prev_nx, d, nxt;
  logic legal, in_seq, vld_nx, ill_nx, serr_nx, inc;
  logic [7:0] err_cnt;
  johnson_to_bin #(.N(N), .IDX_W(IDX_W)) u_dec (.jc(bus.jc), .legal(legal), .idx_raw(d));
  assign nxt = (prev == IDX_W'(2 * N - 1)) ? '0 : prev + 1'b1;
  // Index 0 always restarts legally, but a repeat of the previous index never counts
  assign in_seq = (d != prev) && (d == '0 || d == nxt);
  always_comb begin
    st_nx = st;
    run_nx = run;
    prev_nx = prev;
    vld_nx = 1'b0;
    ill_nx = 1'b0;
    serr_nx = 1'b0;
    inc = 1'b0;
    if (bus.en) begin
      if (!legal) begin
        ill_nx = 1'b1;
        inc = 1'b1;
        run_nx = '0;
        st_nx = ST_UNLOCKED;
      end else begin
        prev_nx = d;
        vld_nx = 1'b1;
        if (in_seq && st == ST_UNLOCKED) begin
          run_nx = (run + 4'd1 == 4'(LOCK_CNT)) ? 4'd0 : run + 4'd1;
          st_nx = (run + 4'd1 == 4'(LOCK_CNT)) ? ST_LOCKED : ST_UNLOCKED;
        end else if (!in_seq) begin
          run_nx = 4'd1;
          serr_nx = (st == ST_LOCKED);
          inc = (st == ST_LOCKED);
          st_nx = ST_UNLOCKED;
        end
      end
    end
  end
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      st <= ST_UNLOCKED;
      run <= '0;
      prev <= '0;
      bus.idx_vld <= 1'b0;
      bus.illegal <= 1'b0;
      bus.seq_err <= 1'b0;
      err_cnt <= '0;
    end else begin
      st <= st_nx;
      run <= run_nx;
      prev <= prev_nx;
      bus.idx_vld <= vld_nx;
      bus.illegal <= ill_nx;
      bus.seq_err <= serr_nx;
      err_cnt <= (inc && err_cnt != ERR_MAX) ? err_cnt + 8'd1 : err_cnt;
    end
  assign bus.idx = prev;
  assign bus.locked = (st == ST_LOCKED);
  assign bus.err_cnt = err_cnt;
endmodule

// File: tb/tb_johnson_decode_checker.sv
// tb_johnson_decode_checker: directed self-checking bench for the Johnson decoder/monitor
module tb_johnson_decode_checker;
  logic clk = 1'b0;
  logic clr;
  int checks = 0;
  int errors = 0;
  johnson_decode_checker_if #(.N(8), .IDX_W(4)) bus ();
  johnson_decode_checker #(.N(8), .IDX_W(4), .LOCK_CNT(3)) dut (.clk(clk), .clr(clr), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, o, e);
    end
  endtask
  task automatic step(input logic e, input logic [7:0] c);
    @(negedge clk);
    bus.en = e;
    bus.jc = c;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [7:0] code_of(input int k);
    logic [7:0] ff;
    ff = 8'hFF;
    return (k <= 8) ? ~(ff >> k) : (ff >> (k - 8));
  endfunction
  task automatic chk_all(input string tag, input int idx, input bit vld, input bit ill,
                         input bit serr, input bit lk, input int ec);
    chk({tag, ".idx"}, 32'(bus.idx), 32'(idx));
    chk({tag, ".vld"}, 32'(bus.idx_vld), 32'(vld));
    chk({tag, ".ill"}, 32'(bus.illegal), 32'(ill));
    chk({tag, ".serr"}, 32'(bus.seq_err), 32'(serr));
    chk({tag, ".lock"}, 32'(bus.locked), 32'(lk));
    chk({tag, ".err"}, 32'(bus.err_cnt), 32'(ec));
  endtask
  initial begin
    int ecnt;
    clr = 1'b0;
    bus.en = 1'b0;
    bus.jc = 8'h00;
    #2 clr = 1'b1;
    #1 chk_all("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    clr = 1'b0;
    // full 16-state walk; first 00 repeats prev=0 so it only starts a run
    for (int k = 0; k <= 16; k++) begin
      step(1'b1, code_of(k));
      chk_all($sformatf("walk%0d", k), k % 16, 1, 0, 0, k >= 2, 0);
    end
    for (int k = 1; k <= 9; k++) begin
      step(1'b1, code_of(k));
      chk_all($sformatf("to9_%0d", k), k, 1, 0, 0, 1, 0);
    end
    step(1'b1, 8'h00);
    chk_all("restart0", 0, 1, 0, 0, 1, 0);
    step(1'b1, 8'h00);
    chk_all("repeat0", 0, 1, 0, 1, 0, 1);
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, code_of(k));
      chk_all($sformatf("to5_%0d", k), k, 1, 0, 0, k >= 2, 1);
    end
    step(1'b1, 8'hA0);
    chk_all("illA0", 5, 0, 1, 0, 0, 2);
    step(1'b1, 8'h00);
    chk_all("relock0", 0, 1, 0, 0, 0, 2);
    step(1'b1, 8'h80);
    chk_all("relock1", 1, 1, 0, 0, 0, 2);
    step(1'b1, 8'hC0);
    chk_all("relock2", 2, 1, 0, 0, 1, 2);
    step(1'b1, 8'hE0);
    chk_all("relock3", 3, 1, 0, 0, 1, 2);
    step(1'b1, 8'hF8);
    chk_all("jump5", 5, 1, 0, 1, 0, 3);
    step(1'b1, 8'hFC);
    chk_all("seq6", 6, 1, 0, 0, 0, 3);
    step(1'b1, 8'hFE);
    chk_all("seq7", 7, 1, 0, 0, 1, 3);
    step(1'b1, 8'hFF);
    chk_all("seq8", 8, 1, 0, 0, 1, 3);
    // asynchronous clear between edges
    #2;
    clr = 1'b1;
    bus.en = 1'b0;
    #1 chk_all("midclr", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    clr = 1'b0;
    step(1'b1, 8'h80);
    chk_all("post1", 1, 1, 0, 0, 0, 0);
    step(1'b1, 8'hC0);
    chk_all("post2", 2, 1, 0, 0, 0, 0);
    step(1'b1, 8'hE0);
    chk_all("post3", 3, 1, 0, 0, 1, 0);
    ecnt = 0;
    for (int i = 0; i < 300; i++) begin
      if (i % 50 == 49) begin
        step(1'b0, 8'h55);
        chk_all($sformatf("idle%0d", i), 3, 0, 0, 0, 0, ecnt);
      end
      step(1'b1, 8'h55);
      ecnt = (ecnt < 255) ? ecnt + 1 : 255;
      chk_all($sformatf("sat%0d", i), 3, 0, 1, 0, 0, ecnt);
    end
    step(1'b0, 8'h55);
    chk_all("satidle", 3, 0, 0, 0, 0, 255);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
